fetch_sequencer: RTL

//  Fetch stage controller: owns the program counter and drives the instruction memory read address.

---
 rtl/fetch_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch stage controller: PC, IF/ID register and bubble insertion
// Bubbles after lw/sw/beq are counted down in a RUN/BUBBLE state machine; redirects beat stalls.
module fetch_sequencer #(
  parameter logic [31:0] PC_RESET       = 32'h0,
  parameter int unsigned LOAD_BUBBLES   = 1,
  parameter int unsigned BRANCH_BUBBLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instr_in,
  output logic [31:0] fetch_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        busy
);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  localparam logic [2:0] LOAD_CNT   = 3'(LOAD_BUBBLES);
  localparam logic [2:0] BRANCH_CNT = 3'(BRANCH_BUBBLES);
  localparam bit         LOAD_EN    = (LOAD_BUBBLES != 0);
  localparam bit         BRANCH_EN  = (BRANCH_BUBBLES != 0);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic        is_mem_op;
  logic        is_beq;

  assign fetch_addr = pc;
  assign pc_plus4   = pc + 32'd4;
  assign opcode     = instr_in[31:26];
  assign is_mem_op  = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_beq     = (opcode == OP_BEQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= PC_RESET;
      state       <= RUN;
      cnt         <= 3'd0;
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
      busy        <= 1'b0;
    end else if (branch_taken) begin
      // A redirect flushes IF/ID and cancels any outstanding bubbles, even while stalled.
      pc          <= branch_target & ~32'h3;
      state       <= RUN;
      cnt         <= 3'd0;
      if_id_instr <= 32'h0;
      if_id_valid <= 1'b0;
      busy        <= 1'b0;
    end else if (!stall) begin
      case (state)
        RUN: begin
          if_id_instr <= instr_in;
          if_id_pc4   <= pc_plus4;
          if_id_valid <= 1'b1;
          pc          <= pc_plus4;
          if (is_mem_op && LOAD_EN) begin
            state <= BUBBLE;
            cnt   <= LOAD_CNT;
            busy  <= 1'b1;
          end else if (is_beq && BRANCH_EN) begin
            state <= BUBBLE;
            cnt   <= BRANCH_CNT;
            busy  <= 1'b1;
          end
        end
        BUBBLE: begin
          // PC and if_id_pc4 hold; instr_in is not sampled here.
          if_id_instr <= 32'h0;
          if_id_valid <= 1'b0;
          cnt         <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
